mux_nto1_rr: RTL
================

// Module: mux_nto1_rr
// PURPOSE
//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every port.
//  Successor to the combinational 2:1 muxes: adds channel-count/width generics, a registered output stage,
//  backpressure, and two selection modes: external select, or round-robin over valid channels.
//  Sits between several producers and a single consumer datapath.
// PARAMETERS
//  WIDTH   8   data width per channel, in bits
//  NCH     4   number of input channels (2..16)
//  SELW    2   width of sel/out_ch; must satisfy 2**SELW >= NCH
// PORTS
//  clk        in   1           single clock; all state updates on the rising edge
//  rst_n      in   1           asynchronous active-low reset
//  in_data    in   NCH*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   NCH         per-channel valid
//  in_ready   out  NCH         per-channel ready; combinational from grant and load_en
//  mode       in   1           0 = external select, 1 = round-robin
//  sel        in   SELW        selected channel when mode=0
//  out_data   out  WIDTH       registered output data
//  out_valid  out  1           registered output valid
//  out_ready  in   1           consumer ready
//  out_ch     out  SELW        index of the channel that sourced out_data
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=NCH-1. The first RR search therefore starts at ch0.
//  - load_en = !out_valid | out_ready. The output register is free, or is being drained this cycle.
//  - Grant is combinational and one-hot; at most one channel is granted per cycle.
//  - Mode 0: grant[sel] = in_valid[sel]. If sel >= NCH, there is no grant and all in_ready=0.
//  - Mode 1: grant goes to the first valid channel searching rr_ptr+1, rr_ptr+2, ... The search wraps modulo NCH.
//  - in_ready[i] = grant[i] & load_en. A transfer happens on channel i when in_valid[i] & in_ready[i].
//  - On a transfer:
//      - out_data <= channel data
//      - out_ch <= i
//      - out_valid <= 1
//      - rr_ptr <= i (rr_ptr also updates in mode 0)
//  - If out_valid & out_ready and there is no transfer, then out_valid <= 0. out_data/out_ch hold their last value.
//  - While out_valid & !out_ready, out_data/out_ch/out_valid stay stable and all in_ready=0.
//  - Latency: 1 cycle from input handshake to out_valid.
//  - Throughput: 1 transfer/cycle when out_ready is held at 1.
//  - Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1 (no bubble).
//  - A mode or sel change applies to the next grant decision only. An already-registered word is unaffected.
//    rr_ptr is kept across mode changes.
//  - Round-robin fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,..,NCH-1,0,...
//  - Async reset mid-transfer: any pending output word is dropped. Outputs return to reset values immediately.
// CONFIGURATION
//  - Macro MUX_NTO1_STAT_EN.
//  - When defined:
//      - adds output port xfer_cnt [15:0]
//      - xfer_cnt increments on each out_valid & out_ready and saturates at 16'hFFFF
//      - reset value is 0
//  - When undefined: the port and the counter logic are absent. All other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
//     Release reset -> first RR grant goes to ch0.
//  2. Mode 0: sel=2, ch2 data=8'hA5, out_ready=1 -> next cycle out_data=A5, out_ch=2, valid=1.
//     sel=5 with NCH=4 -> no grant.
//  3. Mode 1, all 4 channels valid (data 10,11,12,13), out_ready=1 -> out_ch sequence 0,1,2,3,0,
//     one word per cycle with no bubbles.
//  4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0.
//     out_ready=1 -> drain and load happen in the same cycle.
//  5. Sparse RR: only ch1 and ch3 valid, rr_ptr=1 -> grant ch3, then ch1, then ch3.
//     Mode flip to 0 with sel=1 -> ch1 granted.
//  6. With MUX_NTO1_STAT_EN: 20 transfers -> xfer_cnt=20.
//     Preload the counter near the limit -> xfer_cnt saturates at FFFF.
//     Async reset mid-burst -> xfer_cnt=0.

Source files
------------

// File: rtl/mux_nto1_rr_if.sv
// Bus bundle for mux_nto1_rr: per-channel inputs, select controls and the registered output port.
// xfer_cnt exists only when MUX_NTO1_STAT_EN is defined.
interface mux_nto1_rr_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;
`ifdef MUX_NTO1_STAT_EN
  logic [15:0]          xfer_cnt;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch, xfer_cnt
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch, xfer_cnt
  );
`else
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
`endif
endinterface

// File: rtl/mux_nto1_rr.sv
// N-channel registered mux with valid/ready on every port; external select or round-robin.
// Optional transfer counter (xfer_cnt) enabled by defining MUX_NTO1_STAT_EN.
module mux_nto1_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic clk,
  input  logic rst_n,
  mux_nto1_rr_if.slave bus
);

  logic [WIDTH-1:0] w_ch_data [NCH];
  logic [NCH-1:0]   w_grant;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_found;
  logic             w_load_en;
  logic             w_xfer;
  logic [SELW:0]    w_cand;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_ch;
  logic [SELW-1:0]  r_rr_ptr;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign w_ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
  end

  assign w_load_en = !r_out_valid || bus.out_ready;

  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    if (!bus.mode) begin
      if ({1'b0, bus.sel} < (SELW+1)'(NCH)) begin
        w_found   = bus.in_valid[bus.sel];
        w_gnt_idx = bus.sel;
      end
    end else begin
      // Search starts just past the last granted channel and wraps modulo NCH.
      for (int k = 1; k <= NCH; k++) begin
        w_cand = {1'b0, r_rr_ptr} + (SELW+1)'(k);
        if (w_cand >= (SELW+1)'(NCH))
          w_cand = w_cand - (SELW+1)'(NCH);
        if (!w_found && bus.in_valid[w_cand[SELW-1:0]]) begin
          w_found   = 1'b1;
          w_gnt_idx = w_cand[SELW-1:0];
        end
      end
    end
    if (w_found)
      w_grant[w_gnt_idx] = 1'b1;
  end

  // Held in reset no producer may believe a handshake took place.
  assign bus.in_ready = w_grant & {NCH{w_load_en & rst_n}};
  assign w_xfer       = w_found & w_load_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SELW'(NCH-1);
    end else if (w_xfer) begin
      r_out_data  <= w_ch_data[w_gnt_idx];
      r_out_ch    <= w_gnt_idx;
      r_out_valid <= 1'b1;
      r_rr_ptr    <= w_gnt_idx;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;

`ifdef MUX_NTO1_STAT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_xfer_cnt <= '0;
    else if (r_out_valid && bus.out_ready && (r_xfer_cnt != 16'hFFFF))
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
  end

  assign bus.xfer_cnt = r_xfer_cnt;
`endif

endmodule
